four_bit_signed_adder: RTL and testbench

Registered sign-magnitude adder: two 5-bit operands, each a sign bit (bit 4) plus a 4-bit magnitude (bits 3:0), are summed with a carry-in. The block produces a 4-bit result magnitude plus negative, zero, overflow and carry status flags. It is a small arithmetic leaf used by the datapath, with a one-cycle pipelined output and a valid qualifier.

---
 rtl/four_bit_signed_adder.sv | 84 ++++++++
 tb/tb_four_bit_signed_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/four_bit_signed_adder.sv
// Registered sign-magnitude adder with a one-cycle latency and a valid qualifier.
// Optional build macro: SIGNED_ADDER_SATURATE_EN (clamp the result magnitude to 1111 on overflow).
module four_bit_signed_adder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inValid,
   input  logic       carryIn,
   input  logic [4:0] A,
   input  logic [4:0] B,
   output logic [3:0] s,
   output logic       negFlag,
   output logic       zeroFlag,
   output logic       overflowFlag,
   output logic       carryFlag,
   output logic       outValid
);

   logic [3:0] mag_a;
   logic [3:0] mag_b;
   logic       neg_a;
   logic       neg_b;
   logic [5:0] sv_a;
   logic [5:0] sv_b;
   logic [5:0] sum;
   logic [4:0] abs_sum;
   logic [4:0] raw_mag_sum;

   logic [3:0] s_next;
   logic       neg_next;
   logic       zero_next;
   logic       ovf_next;
   logic       carry_next;

   // A sign bit on a zero magnitude (negative zero) contributes nothing.
   always_comb begin
      mag_a = A[3:0];
      mag_b = B[3:0];
      neg_a = A[4] & (|A[3:0]);
      neg_b = B[4] & (|B[3:0]);
      sv_a  = neg_a ? (6'd0 - {2'b00, mag_a}) : {2'b00, mag_a};
      sv_b  = neg_b ? (6'd0 - {2'b00, mag_b}) : {2'b00, mag_b};
   end

   // R spans -30..+31, which fits a 6-bit two's-complement value exactly.
   always_comb begin
      sum         = sv_a + sv_b + {5'd0, carryIn};
      abs_sum     = sum[5] ? 5'(6'd0 - sum) : sum[4:0];
      raw_mag_sum = {1'b0, mag_a} + {1'b0, mag_b} + {4'd0, carryIn};
   end

   always_comb begin
      neg_next   = sum[5];
      zero_next  = (sum == 6'd0);
      ovf_next   = abs_sum[4];
      carry_next = raw_mag_sum[4];
`ifdef SIGNED_ADDER_SATURATE_EN
      s_next     = abs_sum[4] ? 4'hF : abs_sum[3:0];
`else
      s_next     = abs_sum[3:0];
`endif
   end

   // Result registers only load on a sampled operation; outValid tracks inValid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s            <= 4'd0;
         negFlag      <= 1'b0;
         zeroFlag     <= 1'b0;
         overflowFlag <= 1'b0;
         carryFlag    <= 1'b0;
         outValid     <= 1'b0;
      end else begin
         outValid <= inValid;
         if (inValid) begin
            s            <= s_next;
            negFlag      <= neg_next;
            zeroFlag     <= zero_next;
            overflowFlag <= ovf_next;
            carryFlag    <= carry_next;
         end
      end
   end

endmodule

// File: tb/tb_four_bit_signed_adder.sv
// Directed testbench for four_bit_signed_adder with hand-computed expected results.
module tb_four_bit_signed_adder;

   logic       clk;
   logic       rst_n;
   logic       inValid;
   logic       carryIn;
   logic [4:0] A;
   logic [4:0] B;
   logic [3:0] s;
   logic       negFlag;
   logic       zeroFlag;
   logic       overflowFlag;
   logic       carryFlag;
   logic       outValid;

   int checks   = 0;
   int failures = 0;

`ifdef SIGNED_ADDER_SATURATE_EN
   localparam logic [3:0] S_R16  = 4'b1111;
   localparam logic [3:0] S_RM30 = 4'b1111;
`else
   localparam logic [3:0] S_R16  = 4'b0000;
   localparam logic [3:0] S_RM30 = 4'b1110;
`endif

   four_bit_signed_adder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inValid      (inValid),
      .carryIn      (carryIn),
      .A            (A),
      .B            (B),
      .s            (s),
      .negFlag      (negFlag),
      .zeroFlag     (zeroFlag),
      .overflowFlag (overflowFlag),
      .carryFlag    (carryFlag),
      .outValid     (outValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_out(input string tag, input logic [3:0] e_s, input logic e_neg,
                            input logic e_zero, input logic e_ovf, input logic e_carry,
                            input logic e_valid);
      checks++;
      assert (s === e_s) else begin
         failures++;
         $error("FAIL %s.s observed=%b expected=%b", tag, s, e_s);
      end
      checks++;
      assert (negFlag === e_neg) else begin
         failures++;
         $error("FAIL %s.neg observed=%b expected=%b", tag, negFlag, e_neg);
      end
      checks++;
      assert (zeroFlag === e_zero) else begin
         failures++;
         $error("FAIL %s.zero observed=%b expected=%b", tag, zeroFlag, e_zero);
      end
      checks++;
      assert (overflowFlag === e_ovf) else begin
         failures++;
         $error("FAIL %s.ovf observed=%b expected=%b", tag, overflowFlag, e_ovf);
      end
      checks++;
      assert (carryFlag === e_carry) else begin
         failures++;
         $error("FAIL %s.carry observed=%b expected=%b", tag, carryFlag, e_carry);
      end
      checks++;
      assert (outValid === e_valid) else begin
         failures++;
         $error("FAIL %s.valid observed=%b expected=%b", tag, outValid, e_valid);
      end
   endtask

   // Drive one operation, let it be sampled on the next rising edge, then settle.
   task automatic do_op(input logic [4:0] a, input logic [4:0] b, input logic cin);
      A       = a;
      B       = b;
      carryIn = cin;
      inValid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      inValid = 1'b0;
      A       = $urandom_range(0, 31);
      B       = $urandom_range(0, 31);
      carryIn = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      inValid = 1'b0;
      carryIn = 1'b0;
      A       = 5'd0;
      B       = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check_out("reset", 4'b0000, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Test-plan vectors, each issued as an isolated pulse.
      do_op(5'b01000, 5'b00011, 1'b0);
      inValid = 1'b0;
      check_out("p8_p3", 4'b1011, 0, 0, 0, 0, 1);
      do_op(5'b11000, 5'b00011, 1'b0);
      check_out("m8_p3", 4'b0101, 1, 0, 0, 0, 1);
      do_op(5'b01000, 5'b01000, 1'b0);
      check_out("r16", S_R16, 0, 0, 1, 1, 1);
      do_op(5'b10101, 5'b00101, 1'b0);
      check_out("m5_p5", 4'b0000, 0, 1, 0, 0, 1);
      do_op(5'b10000, 5'b10000, 1'b1);
      check_out("negzero_cin", 4'b0001, 0, 0, 0, 0, 1);

      // Range extremes and sign-ignoring carry.
      do_op(5'b11111, 5'b11111, 1'b0);
      check_out("rm30", S_RM30, 1, 0, 1, 1, 1);
      do_op(5'b01111, 5'b01111, 1'b1);
      check_out("r31", 4'b1111, 0, 0, 1, 1, 1);
      do_op(5'b10001, 5'b00000, 1'b1);
      check_out("m1_cin_zero", 4'b0000, 0, 1, 0, 0, 1);
      do_op(5'b00111, 5'b11111, 1'b0);
      check_out("p7_m15", 4'b1000, 1, 0, 0, 1, 1);
      do_op(5'b10011, 5'b10010, 1'b1);
      check_out("m3_m2_cin", 4'b0100, 1, 0, 0, 0, 1);

      // inValid low: results hold, outValid drops.
      idle_cycle();
      check_out("hold1", 4'b0100, 1, 0, 0, 0, 0);
      idle_cycle();
      check_out("hold2", 4'b0100, 1, 0, 0, 0, 0);

      // Mid-stream asynchronous reset discards the in-flight operation.
      do_op(5'b00110, 5'b00001, 1'b0);
      check_out("pre_rst", 4'b0111, 0, 0, 0, 0, 1);
      A       = 5'b01001;
      B       = 5'b00100;
      carryIn = 1'b0;
      inValid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_out("rst_async", 4'b0000, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check_out("rst_held", 4'b0000, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n   = 1'b1;
      inValid = 1'b0;
      @(posedge clk);
      #1;
      check_out("post_rst_idle", 4'b0000, 0, 0, 0, 0, 0);
      do_op(5'b01001, 5'b00100, 1'b0);
      check_out("post_rst_op", 4'b1101, 0, 0, 0, 0, 1);
      idle_cycle();
      check_out("post_rst_drop", 4'b1101, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
